// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT line controller: state encodings, status bit
// positions and the data byte width.
package usrt_pkg;

  localparam int unsigned ByteWidth = 8;

  // Bit positions inside the 4-bit status word.
  localparam int unsigned StatRxValid   = 3;
  localparam int unsigned StatRxOverrun = 2;
  localparam int unsigned StatTxFull    = 1;
  localparam int unsigned StatTxEmpty   = 0;

  typedef enum logic [2:0] {
    s_RX      = 3'd0,
    s_TURN_TX = 3'd1,
    s_TX_LOAD = 3'd2,
    s_TX_WAIT = 3'd3,
    s_TURN_RX = 3'd4
  } usrt_state_e;

endpackage

// File: rtl/usrt_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise the byte is dropped.
module usrt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // The slot being popped frees up this cycle, so a full FIFO can still take a write.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usrt_ctrl.sv
// Half-duplex USRT line controller: buffers bytes to send, owns the line
// direction, gives receive priority and inserts turnaround gaps on each
// direction change. Holds the last received byte and its status for the CPU.
module usrt_ctrl
  import usrt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst,
  input  logic                 i_Tx_En,
  input  logic                 i_Rx_En,
  input  logic [ByteWidth-1:0] i_Pwdata,
  output logic [ByteWidth-1:0] o_Prdata,
  output logic [3:0]           o_Status,
  output logic                 o_Tx_Start,
  output logic [ByteWidth-1:0] o_Tx_Byte,
  input  logic                 i_Tx_Busy,
  output logic                 o_Rx_Arm,
  input  logic                 i_Rx_Busy,
  input  logic                 i_Rx_Valid,
  input  logic [ByteWidth-1:0] i_Rx_Byte,
  output logic                 o_Dir
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);
  localparam logic [GapW-1:0] GapLast = GapW'(1);

  usrt_state_e          state_q;
  usrt_state_e          state_d;
  logic [GapW-1:0]      gap_q;
  logic [GapW-1:0]      gap_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 rx_take;
  logic                 rx_valid_q;
  logic                 rx_overrun_q;
  logic [ByteWidth-1:0] rx_data_q;
  logic                 tx_start_q;
  logic                 dir_q;
  logic                 rx_arm_q;

  // The head is handed to the transmitter in TX_LOAD and retired at the end of it.
  assign fifo_pop = (state_q == s_TX_LOAD);

  usrt_fifo #(
    .WIDTH (ByteWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Pclk),
    .rst   (i_Rst),
    .push  (i_Tx_En),
    .pop   (fifo_pop),
    .wdata (i_Pwdata),
    .head  (o_Tx_Byte),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic; the gap counter is loaded on entry to each turnaround state.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      s_RX: begin
        if (!fifo_empty && !i_Rx_Busy) begin
          state_d = s_TURN_TX;
          gap_d   = GapLoad;
        end
      end
      s_TURN_TX: begin
        if (gap_q <= GapLast) begin
          state_d = s_TX_LOAD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      s_TX_LOAD: begin
        state_d = s_TX_WAIT;
      end
      s_TX_WAIT: begin
        if (!i_Tx_Busy) begin
          if (fifo_empty) begin
            state_d = s_TURN_RX;
            gap_d   = GapLoad;
          end else begin
            state_d = s_TX_LOAD;
          end
        end
      end
      s_TURN_RX: begin
        if (gap_q <= GapLast) begin
          state_d = s_RX;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = s_RX;
      end
    endcase
  end

  // State register with line outputs registered from the next state, so they
  // always match the state they belong to and drop immediately on reset.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= s_RX;
      gap_q      <= '0;
      rx_arm_q   <= 1'b1;
      dir_q      <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      rx_arm_q   <= (state_d == s_RX);
      dir_q      <= (state_d == s_TX_LOAD) || (state_d == s_TX_WAIT);
      tx_start_q <= (state_d == s_TX_LOAD);
    end
  end

  // Received bytes only count while the line is actually listening.
  assign rx_take = i_Rx_Valid && (state_q == s_RX);

  // Receive holding register and its status; a read in the same cycle as a new
  // byte leaves the new byte valid without flagging an overrun.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else if (rx_take) begin
      rx_data_q    <= i_Rx_Byte;
      rx_valid_q   <= 1'b1;
      rx_overrun_q <= i_Rx_En ? 1'b0 : (rx_overrun_q || rx_valid_q);
    end else if (i_Rx_En) begin
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end
  end

  // Status word assembly.
  always_comb begin
    o_Status                = '0;
    o_Status[StatRxValid]   = rx_valid_q;
    o_Status[StatRxOverrun] = rx_overrun_q;
    o_Status[StatTxFull]    = fifo_full;
    o_Status[StatTxEmpty]   = fifo_empty;
  end

  assign o_Prdata   = rx_data_q;
  assign o_Tx_Start = tx_start_q;
  assign o_Dir      = dir_q;
  assign o_Rx_Arm   = rx_arm_q;

endmodule

// File: tb/tb_usrt_ctrl.sv
// Self-checking bench for usrt_ctrl: directed scenarios followed by a random
// phase, scored against a queue-based model of the TX buffer and the RX status rules.
module tb_usrt_ctrl;

  localparam int unsigned Depth = 4;
  localparam int unsigned Gap   = 2;
  localparam int unsigned Frame = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en, rx_en, rx_busy, rx_valid, tx_busy;
  logic [7:0] pwdata, rx_byte;
  logic [7:0] prdata, tx_byte;
  logic [3:0] status;
  logic       tx_start, rx_arm, dir;

  always #5 clk = ~clk;

  usrt_ctrl #(
    .FIFO_DEPTH (Depth),
    .GAP_CYCLES (Gap)
  ) dut (
    .i_Pclk     (clk),
    .i_Rst      (rst),
    .i_Tx_En    (tx_en),
    .i_Rx_En    (rx_en),
    .i_Pwdata   (pwdata),
    .o_Prdata   (prdata),
    .o_Status   (status),
    .o_Tx_Start (tx_start),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Busy  (tx_busy),
    .o_Rx_Arm   (rx_arm),
    .i_Rx_Busy  (rx_busy),
    .i_Rx_Valid (rx_valid),
    .i_Rx_Byte  (rx_byte),
    .o_Dir      (dir)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transmitter stand-in and scoreboards.
  logic       tx_pend = 1'b0;
  int         tx_left = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  int         start_cyc_q[$];
  // Receive-side model.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score this cycle's outputs, update the model, advance.
  task automatic step(input logic ten, input logic [7:0] wd, input logic rv, input logic [7:0] rb,
                      input logic ren, input logic rbsy, input logic live);
    tx_en    = ten;
    pwdata   = wd;
    rx_valid = rv;
    rx_byte  = rb;
    rx_en    = ren;
    rx_busy  = rbsy;
    if (tx_start) begin
      tx_pend = 1'b1;
      start_cyc_q.push_back(cyc);
      sent_q.push_back(tx_byte);
      check("start_dir", dir, 1);
      check("start_has_data", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("tx_byte", tx_byte, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    if (ten && exp_q.size() < Depth) exp_q.push_back(wd);
    if (rv && live) begin
      m_ovr   = ren ? 1'b0 : (m_ovr | m_valid);
      m_valid = 1'b1;
      m_data  = rb;
    end else if (ren) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tx_pend) begin
      tx_busy = 1'b1;
      tx_left = Frame;
      tx_pend = 1'b0;
    end else if (tx_busy) begin
      tx_left--;
      if (tx_left == 0) tx_busy = 1'b0;
    end
    check("status", status, {m_valid, m_ovr, exp_q.size() == Depth, exp_q.size() == 0});
    check("prdata", prdata, m_data);
  endtask

  task automatic idle(input logic rbsy);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, rbsy, 1'b0);
  endtask

  initial begin
    int n0;
    int guard;
    int s;
    logic dir_ok;
    logic rb_state;
    logic ten, rv, ren;

    rst = 1'b1; tx_en = 0; rx_en = 0; rx_busy = 0; rx_valid = 0; tx_busy = 0;
    pwdata = 0; rx_byte = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_status", status, 4'b0001);
    check("rst_rx_arm", rx_arm, 1);
    check("rst_dir", dir, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_prdata", prdata, 0);
    check("rst_tx_byte", tx_byte, 0);
    repeat (8) idle(1'b0);
    check("idle_no_start", sent_q.size(), 0);
    check("idle_rx_arm", rx_arm, 1);

    // Single byte: start latency and return gap.
    n0 = cyc;
    step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (sent_q.size() == 0 && guard < 30) begin idle(1'b0); guard++; end
    check("a5_started", sent_q.size(), 1);
    if (sent_q.size() > 0) begin
      check("a5_latency", start_cyc_q[0] - n0, Gap + 2);
      check("a5_byte", sent_q[0], 8'hA5);
      s = start_cyc_q[0];
      guard = 0;
      while (!rx_arm && guard < 40) begin idle(1'b0); guard++; end
      check("a5_rx_arm_cycle", cyc, s + Frame + 2 + Gap);
    end

    // Fill while the receiver holds the line, then burst out.
    n0 = sent_q.size();
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("burst_full", status[1], 1);
    repeat (6) idle(1'b1);
    check("burst_held", sent_q.size(), n0);
    dir_ok = 1'b1;
    guard = 0;
    while (sent_q.size() < n0 + 4 && guard < 100) begin
      idle(1'b0);
      if (sent_q.size() > n0) dir_ok &= dir;
      guard++;
    end
    check("burst_count", sent_q.size(), n0 + 4);
    check("burst_dir", dir_ok, 1);
    if (sent_q.size() == n0 + 4) begin
      for (int i = 0; i < 4; i++) check("burst_byte", sent_q[n0 + i], 8'(i + 1));
      for (int i = 0; i < 3; i++)
        check("burst_spacing", start_cyc_q[n0 + i + 1] - start_cyc_q[n0 + i], Frame + 2);
    end
    guard = 0;
    while (!rx_arm && guard < 40) begin idle(1'b0); guard++; end
    check("burst_back_to_rx", rx_arm, 1);

    // Receive overrun, read clear, and read colliding with a new byte.
    step(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    check("ovr_prdata", prdata, 8'hC3);
    check("ovr_status", status[3:2], 2'b11);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("read_clear", status[3:2], 2'b00);
    step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    check("collide_prdata", prdata, 8'h77);
    check("collide_status", status[3:2], 2'b10);

    // Reset while waiting on a frame; a byte strobed mid-transmit must be ignored.
    n0 = sent_q.size();
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (sent_q.size() == n0 && guard < 30) begin idle(1'b0); guard++; end
    check("wait_started", sent_q.size(), n0 + 1);
    step(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("wait_dir", dir, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dir", dir, 0);
    check("arst_tx_start", tx_start, 0);
    check("arst_status", status, 4'b0001);
    check("arst_rx_arm", rx_arm, 1);
    exp_q.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
    tx_busy = 1'b0; tx_pend = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    n0 = sent_q.size();
    repeat (15) idle(1'b0);
    check("post_rst_no_start", sent_q.size(), n0);

    // Random traffic in both directions.
    rb_state = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rb_state = ~rb_state;
      ten = ($urandom_range(0, 3) == 0);
      rv  = rx_arm && ($urandom_range(0, 4) == 0);
      ren = ($urandom_range(0, 5) == 0);
      step(ten, 8'($urandom), rv, 8'($urandom), ren, rb_state, rx_arm);
    end
    guard = 0;
    while (!(exp_q.size() == 0 && rx_arm && !tx_busy) && guard < 300) begin
      idle(1'b0);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_rx_arm", rx_arm, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usrt_ctrl.md
# usrt_ctrl

Half-duplex line controller for the USRT. Sits between the APB bus interface (its `o_Tx_En`/`o_Rx_En` access strobes) and the serial transmitter/receiver cores. Buffers written bytes in a small TX FIFO, owns the shared line direction, and arbitrates line time between transmit and receive, with receive priority. Sequences turnaround gaps and holds the last received byte and status for CPU reads.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: TX FIFO entries; power of 2, ≥2.
- `GAP_CYCLES`, 2: turnaround idle cycles on each direction change; ≥1.

Ports:
- `i_Pclk`  in  1  : single clock, all logic on rising edge.
- `i_Rst`  in  1  : reset, asynchronous, active-high.
- `i_Tx_En`  in  1  : one-cycle write strobe from the bus interface; pushes `i_Pwdata`.
- `i_Rx_En`  in  1  : one-cycle read strobe from the bus interface; clears RX status.
- `i_Pwdata`  in  8  : byte to transmit.
- `o_Prdata`  out  8  : last received byte.
- `o_Status`  out  4  : [3] rx_valid, [2] rx_overrun, [1] tx_full, [0] tx_empty.
- `o_Tx_Start`  out  1  : one-cycle transmit request.
- `o_Tx_Byte`  out  8  : FIFO head; valid while `o_Tx_Start`=1.
- `i_Tx_Busy`  in  1  : transmitter busy. Rises the cycle after `o_Tx_Start` and falls when the frame is done.
- `o_Rx_Arm`  out  1  : receiver enabled.
- `i_Rx_Busy`  in  1  : receiver mid-frame.
- `i_Rx_Valid`  in  1  : one-cycle received-byte strobe.
- `i_Rx_Byte`  in  8  : received byte.
- `o_Dir`  out  1  : line direction; 1 = drive (TX), 0 = listen.

## Operation
- States: `s_RX`, `s_TURN_TX`, `s_TX_LOAD`, `s_TX_WAIT`, `s_TURN_RX`. Outputs are Moore-decoded from the state register.
- `s_RX`: `o_Rx_Arm`=1, `o_Dir`=0.
  - Goes to `s_TURN_TX` when the FIFO is non-empty and `i_Rx_Busy`=0.
  - Stays in `s_RX` while `i_Rx_Busy`=1. RX has priority.
- `s_TURN_TX`: `o_Rx_Arm`=0, `o_Dir`=0. Lasts GAP_CYCLES cycles, then goes to `s_TX_LOAD`. Not abortable.
- `s_TX_LOAD`: `o_Dir`=1, `o_Tx_Start`=1, `o_Tx_Byte`=FIFO head. FIFO pops at the end of this cycle. Always lasts 1 cycle, then goes to `s_TX_WAIT`.
- `s_TX_WAIT`: `o_Dir`=1. Exits when `i_Tx_Busy`=0.
  - FIFO non-empty on exit: goes to `s_TX_LOAD`. Burst, no gap.
  - FIFO empty on exit: goes to `s_TURN_RX`.
- `s_TURN_RX`: `o_Rx_Arm`=0, `o_Dir`=0. Lasts GAP_CYCLES cycles, then goes to `s_RX`.
- Unused state encodings go to `s_RX`.
- FIFO push on `i_Tx_En`:
  - Allowed when not full.
  - When full, the push is allowed only if a pop occurs in the same cycle. Otherwise the byte is dropped silently.
  - Simultaneous push and pop leaves the count unchanged.
- RX latch:
  - `i_Rx_Valid` in `s_RX` loads `o_Prdata` and sets rx_valid.
  - If rx_valid was already 1 and `i_Rx_En` is 0 that cycle, rx_overrun is also set; the new byte overwrites the old one.
  - `i_Rx_Valid` outside `s_RX` is ignored.
- `i_Rx_En` clears rx_valid and rx_overrun. On simultaneous `i_Rx_En` and `i_Rx_Valid`: the byte is latched, rx_valid ends at 1, and rx_overrun ends at 0.
- Gap counter width: clog2(GAP_CYCLES+1). It is loaded on entry to each TURN state.

## Timing
- Reset values:
  - state `s_RX`, `o_Rx_Arm`=1, `o_Dir`=0, `o_Tx_Start`=0.
  - `o_Tx_Byte`=0 (FIFO storage cleared), `o_Prdata`=0, `o_Status`=4'b0001.
- Reset asserted mid-frame:
  - `o_Tx_Start` and `o_Dir` drop asynchronously.
  - FIFO is emptied.
  - Pending RX status is lost.
- Write-to-start latency, with a write strobe in cycle N, empty FIFO, state `s_RX` and `i_Rx_Busy`=0:
  - count=1 in cycle N+1.
  - `s_TURN_TX` in cycles N+2 to N+1+GAP_CYCLES.
  - `o_Tx_Start`=1 in cycle N+2+GAP_CYCLES.
- Status bits update the cycle after the causing strobe.
- Back-to-back frames: `o_Tx_Start` follows the first cycle with `i_Tx_Busy`=0 by 1 cycle.

## Structure
- Package `usrt_pkg` contains:
  - state encodings, 3-bit: `s_RX`=0, `s_TURN_TX`=1, `s_TX_LOAD`=2, `s_TX_WAIT`=3, `s_TURN_RX`=4.
  - status bit indices.
  - byte width constant (8).
- Sub-module `usrt_fifo`: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, head, full, empty.
  - Asynchronous reset.
  - Storage and pointers cleared on reset.
- Remaining control: FSM, gap counter and RX latch in `usrt_ctrl`.

## Test plan
- Reset, then idle: `o_Status`=4'b0001, `o_Rx_Arm`=1, `o_Dir`=0, and `o_Tx_Start` never pulses.
- Write 0xA5 with GAP_CYCLES=2: `o_Tx_Start` pulses exactly 4 cycles after the strobe with `o_Tx_Byte`=0xA5. After `i_Tx_Busy` falls, there are 2 gap cycles, then `o_Rx_Arm`=1.
- Write 5 bytes 0x01..0x05 while `i_Rx_Busy`=1 (FIFO_DEPTH=4):
  - tx_full=1 and 0x05 is dropped.
  - No start pulse while RX is busy.
  - On release, 0x01..0x04 go out back-to-back with `o_Dir` held at 1 throughout.
- RX bytes 0x3C then 0xC3 with no read: `o_Prdata`=0xC3 and `o_Status`[3:2]=2'b11. A read strobe then gives [3:2]=2'b00.
- `i_Rx_En` and `i_Rx_Valid` (0x77) in the same cycle with rx_valid=1: `o_Prdata`=0x77, rx_valid=1, rx_overrun=0.
- Reset asserted during `s_TX_WAIT`: `o_Dir` goes to 0 and the FIFO to empty asynchronously. After reset is released, no start pulse occurs.
